// File: rtl/hdmi_video_out.sv
// rtl/hdmi_video_out.sv - raster timing, show-ahead pixel FIFO and ADV7513 parallel bus driver
// Syncs, de, rgb and frame_start are registered together one cycle after the counter state.
module hdmi_video_out #(
  parameter int DW       = 16,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int H_ACT    = 1280,
  parameter int H_FP     = 110,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter int V_ACT    = 720,
  parameter int V_FP     = 5,
  parameter int SYNC_POL = 1,
  parameter int FIFO_AW  = 5,
  parameter int LOW_WM   = 8,
  parameter int HIGH_WM  = 28
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rdy,
  input  logic [1:0]    mode,
  input  logic [DW-1:0] solid_rgb,
  input  logic [DW-1:0] rgb_din,
  input  logic          rgb_din_vld,
  input  logic          clr_status,
  output logic          hdmi_req,
  output logic          hdmi_hsync,
  output logic          hdmi_vsync,
  output logic          hdmi_de,
  output logic          hdmi_clk,
  output logic [DW-1:0] hdmi_rgb,
  output logic          frame_start,
  output logic          underflow,
  output logic          overflow,
  output logic [15:0]   underflow_cnt
);

  localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;
  localparam logic [15:0] H_LAST   = 16'(H_TOT - 1);
  localparam logic [15:0] HS_END   = 16'(H_SYNC);
  localparam logic [15:0] HA_BEG   = 16'(H_SYNC + H_BP);
  localparam logic [15:0] HA_END   = 16'(H_SYNC + H_BP + H_ACT);
  localparam logic [15:0] V_LAST   = 16'(V_TOT - 1);
  localparam logic [15:0] VS_END   = 16'(V_SYNC);
  localparam logic [15:0] VA_BEG   = 16'(V_SYNC + V_BP);
  localparam logic [15:0] VA_END   = 16'(V_SYNC + V_BP + V_ACT);
  localparam logic [15:0] BAR_LAST = 16'(H_ACT / 8 - 1);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_C  = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0] LOW_C   = (FIFO_AW + 1)'(LOW_WM);
  localparam logic [FIFO_AW:0] HIGH_C  = (FIFO_AW + 1)'(HIGH_WM);
  localparam logic [FIFO_AW:0] CNT_ONE = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);
  localparam logic SYNC_ON = (SYNC_POL != 0);
  localparam int RW = (DW == 24) ? 8 : 5;
  localparam int GW = (DW == 24) ? 8 : 6;

  logic                run_q, run_d;
  logic [15:0]         h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [1:0]          mode_q, mode_d;
  logic [15:0]         bar_cnt_q, bar_cnt_d;
  logic [2:0]          bar_idx_q, bar_idx_d;
  logic [DW-1:0]       mem_q [DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]    count_q, count_d;
  logic                hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d, fs_q, fs_d;
  logic [DW-1:0]       rgb_q, rgb_d;
  logic                req_q, req_d, unf_q, unf_d, ovf_q, ovf_d;
  logic [15:0]         unf_cnt_q, unf_cnt_d;

  logic h_act, v_act, de_c, stream, empty, full, push, pop, unf_evt, ovf_evt;
  logic [DW-1:0] bar_rgb;

  always_comb begin
    h_act   = (h_cnt_q >= HA_BEG) && (h_cnt_q < HA_END);
    v_act   = (v_cnt_q >= VA_BEG) && (v_cnt_q < VA_END);
    de_c    = run_q && h_act && v_act;
    stream  = (mode_q == 2'd0);
    empty   = (count_q == '0);
    full    = (count_q == FULL_C);
    push    = rgb_din_vld && !full;
    pop     = de_c && stream && !empty;
    ovf_evt = rgb_din_vld && full;
    unf_evt = de_c && stream && empty;
    // Bar colours are just on/off per component: R off for idx 2,3,6,7, G off for 4..7, B off for odd.
    bar_rgb = {{RW{~bar_idx_q[1]}}, {GW{~bar_idx_q[2]}}, {RW{~bar_idx_q[0]}}};
  end

  always_comb begin
    run_d   = run_q | rdy;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (run_q) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 16'd1;
      end else begin
        h_cnt_d = h_cnt_q + 16'd1;
      end
    end
    mode_d = mode_q;
    if ((!run_q && rdy) || (run_q && h_cnt_q == '0 && v_cnt_q == '0)) mode_d = mode;

    bar_cnt_d = '0;
    bar_idx_d = '0;
    if (h_act) begin
      if (bar_cnt_q == BAR_LAST) begin
        bar_idx_d = bar_idx_q + 3'd1;
      end else begin
        bar_cnt_d = bar_cnt_q + 16'd1;
        bar_idx_d = bar_idx_q;
      end
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) count_d = count_q + CNT_ONE;
    else if (pop && !push) count_d = count_q - CNT_ONE;

    hsync_d = (run_q && h_cnt_q < HS_END) ? SYNC_ON : ~SYNC_ON;
    vsync_d = (run_q && v_cnt_q < VS_END) ? SYNC_ON : ~SYNC_ON;
    de_d    = de_c;
    fs_d    = run_q && (h_cnt_q == '0) && (v_cnt_q == '0);
    rgb_d   = '0;
    if (de_c) begin
      case (mode_q)
        2'd0:    rgb_d = empty ? '0 : mem_q[rd_ptr_q];
        2'd1:    rgb_d = bar_rgb;
        default: rgb_d = solid_rgb;
      endcase
    end

    // Hysteresis between the two watermarks; the request holds its value in between.
    req_d = req_q;
    if (!run_q || !stream) req_d = 1'b0;
    else if (count_q <= LOW_C) req_d = 1'b1;
    else if (count_q >= HIGH_C) req_d = 1'b0;

    unf_d     = unf_q | unf_evt;
    ovf_d     = ovf_q | ovf_evt;
    unf_cnt_d = (unf_evt && unf_cnt_q != 16'hFFFF) ? unf_cnt_q + 16'd1 : unf_cnt_q;
    if (clr_status) begin
      unf_d     = 1'b0;
      ovf_d     = 1'b0;
      unf_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rgb_din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_q     <= 1'b0;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      mode_q    <= '0;
      bar_cnt_q <= '0;
      bar_idx_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      hsync_q   <= ~SYNC_ON;
      vsync_q   <= ~SYNC_ON;
      de_q      <= 1'b0;
      fs_q      <= 1'b0;
      rgb_q     <= '0;
      req_q     <= 1'b0;
      unf_q     <= 1'b0;
      ovf_q     <= 1'b0;
      unf_cnt_q <= '0;
    end else begin
      run_q     <= run_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      mode_q    <= mode_d;
      bar_cnt_q <= bar_cnt_d;
      bar_idx_q <= bar_idx_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      de_q      <= de_d;
      fs_q      <= fs_d;
      rgb_q     <= rgb_d;
      req_q     <= req_d;
      unf_q     <= unf_d;
      ovf_q     <= ovf_d;
      unf_cnt_q <= unf_cnt_d;
    end
  end

  assign hdmi_req      = req_q;
  assign hdmi_hsync    = hsync_q;
  assign hdmi_vsync    = vsync_q;
  assign hdmi_de       = de_q;
  assign hdmi_clk      = ~clk;
  assign hdmi_rgb      = rgb_q;
  assign frame_start   = fs_q;
  assign underflow     = unf_q;
  assign overflow      = ovf_q;
  assign underflow_cnt = unf_cnt_q;

endmodule

// File: tb/tb_hdmi_video_out.sv
// tb/tb_hdmi_video_out.sv - scoreboard bench for hdmi_video_out on a 15x7 raster
module tb_hdmi_video_out;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rdy, rgb_din_vld, clr_status;
  logic [1:0]  mode;
  logic [15:0] solid_rgb, rgb_din;
  logic        hdmi_req, hdmi_hsync, hdmi_vsync, hdmi_de, hdmi_clk, frame_start;
  logic        underflow, overflow;
  logic [15:0] hdmi_rgb, underflow_cnt;

  logic        rst2_n, rdy2;
  logic [1:0]  mode2 = 2'd1;
  logic [15:0] zero16 = 16'd0;
  logic        zero1 = 1'b0;
  logic        req2, hs2, vs2, de2, clk2, fs2, unf2, ovf2;
  logic [15:0] rgb2, unf_cnt2;

  hdmi_video_out #(.DW(16), .H_SYNC(2), .H_BP(3), .H_ACT(8), .H_FP(2),
                   .V_SYNC(1), .V_BP(1), .V_ACT(4), .V_FP(1), .SYNC_POL(1),
                   .FIFO_AW(3), .LOW_WM(2), .HIGH_WM(6)) u_dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .mode(mode), .solid_rgb(solid_rgb),
    .rgb_din(rgb_din), .rgb_din_vld(rgb_din_vld), .clr_status(clr_status),
    .hdmi_req(hdmi_req), .hdmi_hsync(hdmi_hsync), .hdmi_vsync(hdmi_vsync),
    .hdmi_de(hdmi_de), .hdmi_clk(hdmi_clk), .hdmi_rgb(hdmi_rgb),
    .frame_start(frame_start), .underflow(underflow), .overflow(overflow),
    .underflow_cnt(underflow_cnt));

  hdmi_video_out #(.DW(16), .H_SYNC(2), .H_BP(3), .H_ACT(8), .H_FP(2),
                   .V_SYNC(1), .V_BP(1), .V_ACT(4), .V_FP(1), .SYNC_POL(0),
                   .FIFO_AW(3), .LOW_WM(2), .HIGH_WM(6)) u_neg (
    .clk(clk), .rst_n(rst2_n), .rdy(rdy2), .mode(mode2), .solid_rgb(zero16),
    .rgb_din(zero16), .rgb_din_vld(zero1), .clr_status(zero1),
    .hdmi_req(req2), .hdmi_hsync(hs2), .hdmi_vsync(vs2),
    .hdmi_de(de2), .hdmi_clk(clk2), .hdmi_rgb(rgb2),
    .frame_start(fs2), .underflow(unf2), .overflow(ovf2),
    .underflow_cnt(unf_cnt2));

  int total = 0;
  int bad = 0;
  logic [15:0] exp_q[$];
  logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};
  bit feed_en = 1'b0;
  logic [15:0] feed_val;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // sel: 0 = frame_start, 1 = de, 2 = fs2, 3 = de2
  task automatic wait_for(input int sel, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((sel == 0 && frame_start) || (sel == 1 && hdmi_de) ||
          (sel == 2 && fs2) || (sel == 3 && de2)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic restart();
    check("sb_drained", exp_q.size(), 0);
    exp_q.delete();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_rdy();
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (hdmi_de === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_extra_pixel: got %0h expected none", hdmi_rgb);
        end else begin
          check("sb_pixel", hdmi_rgb, exp_q.pop_front());
        end
      end
    end
  end

  initial begin : feeder
    forever begin
      @(negedge clk);
      if (feed_en) begin
        if (hdmi_req) begin
          rgb_din     = feed_val;
          rgb_din_vld = 1'b1;
          feed_val    = feed_val + 16'd1;
        end else begin
          rgb_din_vld = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    bit ok;
    int hs_n, vs_n, de_n, fs_n, act_n;
    rst_n = 1'b0; rst2_n = 1'b0; rdy = 1'b0; rdy2 = 1'b0; mode = 2'd0;
    solid_rgb = 16'd0; rgb_din = 16'd0; rgb_din_vld = 1'b0; clr_status = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_hsync", hdmi_hsync, 0);
    check("rst_vsync", hdmi_vsync, 0);
    check("rst_de_rgb_fs", {hdmi_de, frame_start, hdmi_rgb}, 0);
    check("rst_req", hdmi_req, 0);
    check("rst_flags", {underflow, overflow, underflow_cnt}, 0);
    check("rst_neg_syncs", {hs2, vs2}, 2'b11);
    rst_n = 1'b1; rst2_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_no_raster", {hdmi_hsync, hdmi_de, frame_start}, 0);

    // Colour bars, raster timing, then a mid-frame switch to solid colour.
    for (int i = 0; i < 32; i++) exp_q.push_back(bars[i % 8]);
    for (int i = 0; i < 32; i++) exp_q.push_back(16'hF81F);
    mode = 2'd1;
    pulse_rdy();
    wait_for(0, 10, ok);
    check("t1_fs_seen", ok, 1);
    hs_n = 0; vs_n = 0; de_n = 0; fs_n = 0;
    for (int i = 0; i < 105; i++) begin
      hs_n += int'(hdmi_hsync);
      vs_n += int'(hdmi_vsync);
      de_n += int'(hdmi_de);
      fs_n += int'(frame_start);
      if (i == 40) begin
        mode = 2'd2;
        solid_rgb = 16'hF81F;
      end
      @(negedge clk);
    end
    check("t1_hsync_cycles", hs_n, 14);
    check("t1_vsync_cycles", vs_n, 15);
    check("t1_de_cycles", de_n, 32);
    check("t1_fs_per_frame", fs_n, 1);
    check("t1_fs_period", frame_start, 1);
    repeat (104) @(negedge clk);
    restart();
    mode = 2'd0;
    solid_rgb = 16'd0;

    // Overflow and watermarks: 9 writes before any active pixel.
    for (int i = 1; i <= 8; i++) exp_q.push_back(16'(i));
    for (int i = 0; i < 24; i++) exp_q.push_back(16'h0000);
    pulse_rdy();
    for (int j = 1; j <= 9; j++) begin
      rgb_din = 16'(j);
      rgb_din_vld = 1'b1;
      @(negedge clk);
      if (j == 6) check("ov_req_held_at5", hdmi_req, 1);
      if (j == 7) check("ov_req_clear_at6", hdmi_req, 0);
    end
    rgb_din_vld = 1'b0;
    check("ov_overflow_set", overflow, 1);
    check("ov_no_underflow_yet", underflow, 0);
    wait_for(1, 60, ok);
    check("ov_de_seen", ok, 1);
    for (int k = 1; k <= 8; k++) begin
      if (k == 6) check("ov_req_low_at3", hdmi_req, 0);
      if (k == 7) check("ov_req_set_at2", hdmi_req, 1);
      @(negedge clk);
    end
    wait_for(0, 200, ok);
    check("ov_fs2_seen", ok, 1);
    check("ov_underflow_cnt", underflow_cnt, 24);
    check("ov_flags", {underflow, overflow}, 2'b11);
    restart();

    // Starvation: stream mode with no writes.
    for (int i = 0; i < 32; i++) exp_q.push_back(16'h0000);
    pulse_rdy();
    wait_for(0, 10, ok);
    check("st_fs1_seen", ok, 1);
    wait_for(0, 120, ok);
    check("st_fs2_seen", ok, 1);
    check("st_underflow", underflow, 1);
    check("st_underflow_cnt", underflow_cnt, 32);
    check("st_req", hdmi_req, 1);
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    check("st_cleared", {underflow, overflow, underflow_cnt}, 0);
    restart();

    // Stream: preload 8, then feed while hdmi_req is high.
    for (int i = 1; i <= 32; i++) exp_q.push_back(16'(i));
    for (int j = 1; j <= 8; j++) begin
      rgb_din = 16'(j);
      rgb_din_vld = 1'b1;
      @(negedge clk);
    end
    rgb_din_vld = 1'b0;
    check("sm_req_idle", hdmi_req, 0);
    feed_val = 16'd9;
    feed_en = 1'b1;
    pulse_rdy();
    wait_for(0, 10, ok);
    check("sm_fs1_seen", ok, 1);
    wait_for(0, 120, ok);
    check("sm_fs2_seen", ok, 1);
    check("sm_no_errors", {underflow, overflow, underflow_cnt}, 0);
    feed_en = 1'b0;
    rgb_din_vld = 1'b0;
    restart();

    // Active-low syncs with a mid-line reset.
    rdy2 = 1'b1;
    @(negedge clk);
    rdy2 = 1'b0;
    wait_for(3, 80, ok);
    check("neg_de_seen", ok, 1);
    rst2_n = 1'b0;
    @(negedge clk);
    check("neg_rst_syncs", {hs2, vs2}, 2'b11);
    check("neg_rst_outputs", {de2, fs2, req2, rgb2}, 0);
    @(negedge clk);
    rst2_n = 1'b1;
    act_n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!hs2 || !vs2 || de2 || fs2) act_n++;
    end
    check("neg_no_activity", act_n, 0);
    rdy2 = 1'b1;
    @(negedge clk);
    rdy2 = 1'b0;
    wait_for(2, 10, ok);
    check("neg_fs_seen", ok, 1);
    check("neg_sync_active_low", {hs2, vs2}, 2'b00);

    check("sb_final_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hdmi_video_out.md
# hdmi_video_out

Parametrised HDMI transmitter front end: generates programmable raster timing (hsync/vsync/de), buffers incoming pixels in an internal show-ahead FIFO with watermark-based refill requests, and drives the ADV7513 parallel video bus. It sits between the frame-buffer read path and the HDMI encoder pins. It adds selectable sync polarity, built-in test patterns, frame-aligned mode switching and underflow/overflow reporting.

## Interface
- DW, 16, pixel width; 16 = RGB565, 24 = RGB888 (only legal values)
- H_SYNC / H_BP / H_ACT / H_FP, 40 / 220 / 1280 / 110, horizontal sync, back porch, active, front porch in pixels; H_ACT multiple of 8
- V_SYNC / V_BP / V_ACT / V_FP, 5 / 20 / 720 / 5, vertical equivalents in lines
- SYNC_POL, 1, 1 = active-high syncs, 0 = active-low
- FIFO_AW, 5, FIFO address width; depth 2^FIFO_AW
- LOW_WM / HIGH_WM, 8 / 28, refill request set/clear thresholds (LOW_WM < HIGH_WM < 2^FIFO_AW)

- clk  in  1  pixel clock
- rst_n  in  1  synchronous active-low reset
- rdy  in  1  start; first high sample starts the raster, ignored thereafter
- mode  in  2  0 stream, 1 colour bars, 2 solid colour, 3 treated as 2
- solid_rgb  in  DW  colour for mode 2
- rgb_din  in  DW  pixel to buffer
- rgb_din_vld  in  1  write strobe for rgb_din
- clr_status  in  1  clears sticky flags and counter
- hdmi_req  out  1  refill request to upstream reader
- hdmi_hsync / hdmi_vsync  out  1 each  syncs, polarity per SYNC_POL
- hdmi_de  out  1  active video
- hdmi_clk  out  1  ~clk
- hdmi_rgb  out  DW  pixel data, 0 outside active
- frame_start  out  1  one-cycle pulse with first sync cycle of each frame
- underflow / overflow  out  1 each  sticky error flags
- underflow_cnt  out  16  saturating count of starved active pixels

## Operation
- Run latch: cleared by reset, set on rdy=1; h_cnt/v_cnt held at 0 until set.
- h_cnt counts 0..H_TOT-1 (H_TOT = sum of H params); v_cnt increments on h wrap, 0..V_TOT-1. Both wrap to 0.
- Line layout from h_cnt=0: sync [0,H_SYNC), back porch, active [H_SYNC+H_BP, H_SYNC+H_BP+H_ACT), front porch. Vertical identical on v_cnt.
- de_c = h active AND v active. Sync asserted (per SYNC_POL) while counter in sync region.
- Mode latched into mode_q only when h_cnt=0 and v_cnt=0 (and on run start); mid-frame changes take effect next frame.
- FIFO: show-ahead, depth 2^FIFO_AW, count 0..2^FIFO_AW. Push = rgb_din_vld AND NOT full; vld while full drops data and sets overflow, even with a simultaneous pop. Pop = de_c AND mode_q=0 AND NOT empty. Push+pop same cycle: count unchanged.
- Stream mode, de_c with FIFO empty: output pixel 0, set underflow, underflow_cnt +1 saturating at 0xFFFF.
- hdmi_req: set when count <= LOW_WM, cleared when count >= HIGH_WM, otherwise held; forced 0 when mode_q != 0 or not running.
- Colour bars: 8 bars of H_ACT/8 pixels, left to right white, yellow, cyan, green, magenta, red, blue, black; full-scale components (RGB565 FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000; RGB888 equivalents). Bar index from a column counter reset at active start, not a divider.
- clr_status: clears underflow, overflow, underflow_cnt. If it coincides with a new error event, the clear wins.

## Timing
- All outputs except hdmi_clk are registered. hsync, vsync, de, rgb and frame_start are mutually aligned, 1 cycle after the counter state that produces them.
- The popped pixel appears on hdmi_rgb in the same cycle hdmi_de is high.
- Reset values: hsync/vsync = inactive level (~SYNC_POL), de 0, rgb 0, req 0, frame_start 0, flags 0, cnt 0, FIFO empty, run latch 0, mode_q 0.
- Reset mid-frame flushes the FIFO and restarts timing only after a new rdy.
- hdmi_req responds 1 cycle after the count crosses a threshold.

## Test plan
Bench parameters: H 2/3/8/2 (H_TOT 15), V 1/1/4/1 (V_TOT 7), FIFO_AW 3, LOW_WM 2, HIGH_WM 6, DW 16.
- Timing: rdy pulse, mode 1 -> hsync 2 cycles per 15; de 8 cycles on lines 2-5; frame_start every 105 cycles; bars FFFF,FFE0,...,0000, one pixel each.
- Stream: preload 8 pixels 0x0001..0x0008, keep feeding while hdmi_req=1 -> each active line outputs consecutive values; underflow stays 0.
- Starvation: mode 0, no writes -> hdmi_rgb=0 during de; underflow=1; underflow_cnt=32 after one frame; clr_status -> all 0.
- Overflow: 9 writes with no reads -> overflow=1, first 8 values retained; hdmi_req set at count 2, cleared at count 6.
- Mode switch mid-frame from 1 to 2 with solid_rgb=F81F -> bars finish the current frame, F81F from the next frame_start.
- SYNC_POL=0 and reset asserted mid-line -> syncs idle high, all outputs take reset values next cycle; no activity until rdy.
